// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, Rcon, GF(2^8) helpers and FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {StIdle, StInit, StRound, StLast, StHold} aes_state_e;

  // Element 0 is the leftmost byte, so SBOX[b] is a direct lookup.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Index 0 is unused; key-schedule words index Rcon[i/NK] from 1.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// Combinational AES key schedule.
//   key_i : cipher key, MSB = key byte 0
//   rk_o  : round keys rk[0..NR], rk[r] at bits [r*128 +: 128]
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6
) (
  input  logic [NK*32-1:0]      key_i,
  output logic [(NR+1)*128-1:0] rk_o
);

  localparam int unsigned NW = 4 * (NR + 1);

  logic [31:0] w [NW];

  // Single process so the word-to-word chain is evaluated in order.
  always_comb begin
    logic [31:0] tmp;
    tmp = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = key_i[NK*32-1-32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % NK == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON[i/NK], 24'h0};
        end else if (NK > 6 && i % NK == 4) begin
          tmp = sub_word(tmp);  // AES-256 only
        end
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int r = 0; r <= NR; r++) begin
      rk_o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  end

endmodule

// File: rtl/aes_round_unit.sv
// One combinational AES round, forward or inverse.
//   state_i      : current state, byte 0 in the MSB
//   round_key_i  : round key for this round
//   mode_i       : 0 = encrypt, 1 = decrypt
//   last_i       : final round, (Inv)MixColumns skipped
//   next_state_o : state after the round
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         mode_i,
  input  logic         last_i,
  output logic [127:0] next_state_o
);

  // Row i output coefficient for input byte j is coef byte (j-i) mod 4.
  function automatic logic [31:0] mix_word(input logic [31:0] a, input logic [31:0] coef);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b[31-8*i -: 8] = b[31-8*i -: 8] ^
                         gmul(a[31-8*j -: 8], coef[31-8*((j-i+4)%4) -: 8]);
      end
    end
    return b;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic [31:0] coef);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_word(s[127-32*c -: 32], coef);
    return o;
  endfunction

  logic [127:0] sb_enc, sb_dec, ak_dec;

  always_comb begin
    sb_enc = '0;
    sb_dec = '0;
    // Byte (row r, column c) sits at index 4c+r; shift and substitute in one pass.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb_enc[127-8*(4*c+r) -: 8] = SBOX[state_i[127-8*(4*((c+r)%4)+r) -: 8]];
        sb_dec[127-8*(4*c+r) -: 8] = INV_SBOX[state_i[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    ak_dec = sb_dec ^ round_key_i;
    if (!mode_i) begin
      next_state_o = (last_i ? sb_enc : mix_cols(sb_enc, 32'h02030101)) ^ round_key_i;
    end else begin
      next_state_o = last_i ? ak_dec : mix_cols(ak_dec, 32'h0e0b0d09);
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : block handshake for data_in, key_in, mode
//   out_valid/out_ready : result handshake for data_out
//   busy                : high whenever not idle
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   data_in,
  input  logic [NK*32-1:0] key_in,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   data_out,
  output logic           busy
);

  localparam int unsigned NR = NK + 6;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  aes_state_e              state_q;
  logic [3:0]              rnd_q;
  logic [127:0]            blk_q;
  logic [NK*32-1:0]        key_q;
  logic                    mode_q;
  logic [(NR+1)*128-1:0]   rk_all;
  logic [3:0]              rk_idx;
  logic [127:0]            rk_sel;
  logic [127:0]            blk_d;

  aes_key_expansion #(
    .NK (NK),
    .NR (NR)
  ) u_key_expansion (
    .key_i (key_q),
    .rk_o  (rk_all)
  );

  // Decrypt walks the schedule backwards; rnd_q is 0 in INIT and NR in LAST,
  // so one index expression covers every state.
  assign rk_idx = mode_q ? 4'(NR) - rnd_q : rnd_q;
  assign rk_sel = rk_all[int'(rk_idx)*128 +: 128];

  aes_round_unit u_round_unit (
    .state_i      (blk_q),
    .round_key_i  (rk_sel),
    .mode_i       (mode_q),
    .last_i       (state_q == StLast),
    .next_state_o (blk_d)
  );

  assign in_ready = (state_q == StIdle) && !rst;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rnd_q     <= '0;
      blk_q     <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            blk_q   <= data_in;
            key_q   <= key_in;
            mode_q  <= mode;
            rnd_q   <= '0;
            state_q <= StInit;
          end
        end
        StInit: begin
          blk_q   <= blk_q ^ rk_sel;
          rnd_q   <= 4'd1;
          state_q <= StRound;
        end
        StRound: begin
          blk_q <= blk_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) state_q <= StLast;
        end
        StLast: begin
          data_out  <= blk_d;
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: one instance each for AES-128/192/256.
module tb_aes_iter_core;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT [3] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'hdda97ca4864cdfe06eaf70a0ec0d7191,
    128'h8ea2b7ca516745bfeafc49904b496089
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic [127:0] data_in_v   [3];
  logic [255:0] key_v       [3];
  logic         mode_v      [3];
  logic         out_valid_v [3];
  logic         out_ready_v [3];
  logic [127:0] data_out_v  [3];
  logic         busy_v      [3];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_core #(.NK(4)) u_aes128 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .data_in(data_in_v[0]), .key_in(key_v[0][255:128]), .mode(mode_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .data_out(data_out_v[0]),
    .busy(busy_v[0])
  );

  aes_iter_core #(.NK(6)) u_aes192 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .data_in(data_in_v[1]), .key_in(key_v[1][255:64]), .mode(mode_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .data_out(data_out_v[1]),
    .busy(busy_v[1])
  );

  aes_iter_core #(.NK(8)) u_aes256 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .data_in(data_in_v[2]), .key_in(key_v[2]), .mode(mode_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .data_out(data_out_v[2]),
    .busy(busy_v[2])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int u, input logic [127:0] din, input logic m, output int acc);
    int guard;
    guard = 0;
    while (in_ready_v[u] !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check_eq("in_ready before send", 128'(in_ready_v[u]), 128'd1);
    in_valid_v[u] = 1'b1;
    data_in_v[u]  = din;
    key_v[u]      = KEY;
    mode_v[u]     = m;
    @(negedge clk);
    acc = cyc;
    in_valid_v[u] = 1'b0;
  endtask

  task automatic get_result(input int u, input string tag, input logic [127:0] exp);
    int lat;
    lat = 0;
    while (out_valid_v[u] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 128'(lat), 128'(11 + 2 * u));
    check_eq({tag, " data"}, data_out_v[u], exp);
  endtask

  task automatic release_out(input int u, input string tag);
    out_ready_v[u] = 1'b1;
    @(negedge clk);
    out_ready_v[u] = 1'b0;
    check_eq({tag, " out_valid after release"}, 128'(out_valid_v[u]), 128'd0);
    check_eq({tag, " in_ready after release"}, 128'(in_ready_v[u]), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2;
    logic [127:0] rnd_data;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid_v[u] = 1'b0; data_in_v[u] = '0; key_v[u] = '0;
      mode_v[u] = 1'b0; out_ready_v[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_eq("in_ready during rst", 128'(in_ready_v[0]), 128'd0);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      check_eq("reset busy", 128'(busy_v[u]), 128'd0);
      check_eq("reset out_valid", 128'(out_valid_v[u]), 128'd0);
      check_eq("reset data_out", data_out_v[u], 128'd0);
      check_eq("reset in_ready", 128'(in_ready_v[u]), 128'd1);
    end
    @(negedge clk);

    // Encrypt then decrypt for each key size.
    for (int u = 0; u < 3; u++) begin
      send(u, PT, 1'b0, acc1);
      get_result(u, $sformatf("enc nk%0d", 4 + 2 * u), CT[u]);
      release_out(u, "enc");
      send(u, CT[u], 1'b1, acc1);
      get_result(u, $sformatf("dec nk%0d", 4 + 2 * u), PT);
      release_out(u, "dec");
    end

    // Backpressure: result must hold while inputs toggle.
    send(0, PT, 1'b0, acc1);
    get_result(0, "bp enc", CT[0]);
    for (int i = 0; i < 20; i++) begin
      rnd_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid_v[0] = ~in_valid_v[0];
      mode_v[0]     = ~mode_v[0];
      data_in_v[0]  = rnd_data;
      @(negedge clk);
      check_eq("bp data_out", data_out_v[0], CT[0]);
      check_eq("bp out_valid", 128'(out_valid_v[0]), 128'd1);
      check_eq("bp in_ready", 128'(in_ready_v[0]), 128'd0);
    end
    in_valid_v[0] = 1'b0;
    mode_v[0]     = 1'b0;
    release_out(0, "bp");

    // Reset in round 5 abandons the block.
    send(0, PT, 1'b0, acc1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid rst in_ready", 128'(in_ready_v[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid rst busy", 128'(busy_v[0]), 128'd0);
    check_eq("mid rst out_valid", 128'(out_valid_v[0]), 128'd0);
    check_eq("mid rst data_out", data_out_v[0], 128'd0);
    check_eq("mid rst in_ready", 128'(in_ready_v[0]), 128'd1);
    repeat (15) @(negedge clk);
    check_eq("abandoned out_valid", 128'(out_valid_v[0]), 128'd0);
    send(0, CT[0], 1'b1, acc1);
    get_result(0, "post rst dec", PT);
    release_out(0, "post rst");

    // Back-to-back with out_ready tied high.
    for (int u = 0; u < 3; u += 2) begin
      out_ready_v[u] = 1'b1;
      send(u, PT, 1'b0, acc1);
      get_result(u, "b2b enc", CT[u]);
      @(negedge clk);
      send(u, CT[u], 1'b1, acc2);
      check_eq("b2b spacing", 128'(acc2 - acc1), 128'(13 + 2 * u));
      get_result(u, "b2b dec", PT);
      @(negedge clk);
      out_ready_v[u] = 1'b0;
      check_eq("b2b idle", 128'(busy_v[u]), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
